// File: rtl/mem_pkg.sv
// Shared memory-side definitions: widths, block type and responder FSM states.
package mem_pkg;
  localparam int WORD_LEN        = 32;
  localparam int ADDR_LEN        = 15;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int BLOCK_LEN       = WORD_LEN * WORDS_PER_BLOCK;  // 128
  localparam int LATENCY         = 4;
  localparam int CNT_W           = 4;

  // Word k of a block lives at bits [32k+31:32k]; the cache slices the same way.
  typedef logic [BLOCK_LEN-1:0] block_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;
endpackage

// File: rtl/mem_word_array.sv
// Word-addressed storage split into one bank per word offset so a whole block
// can be tapped at once. Reads are asynchronous; the consumer registers the tap,
// so a write landing on the sampling edge is not seen (read-before-write).
module mem_word_array #(
  parameter int ADDR_LEN = 15,
  parameter int WORD_LEN = 32,
  parameter int WORDS    = 4
) (
  input  logic                            clk,
  input  logic                            wr_en,
  input  logic [ADDR_LEN-1:0]             wr_addr,
  input  logic [WORD_LEN-1:0]             wr_data,
  input  logic [ADDR_LEN-3:0]             rd_addr,
  output logic [WORDS-1:0][WORD_LEN-1:0]  rd_words
);
  localparam int BANK_DEPTH = 2 ** (ADDR_LEN - 2);

  for (genvar b = 0; b < WORDS; b++) begin : g_bank
    logic [WORD_LEN-1:0] mem [BANK_DEPTH];

    // Write this bank when the word offset selects it; no reset on contents.
    always_ff @(posedge clk) begin
      if (wr_en && (wr_addr[1:0] == 2'(b)))
        mem[wr_addr[ADDR_LEN-1:2]] <= wr_data;
    end

    assign rd_words[b] = mem[rd_addr];
  end
endmodule

// File: rtl/block_fill_memory.sv
// Block-fill responder for the cache miss path: accept a block request, wait a
// fixed latency, then present the 4-word block until the cache takes it.
// LATENCY must lie in 1..15 to fit the 4-bit countdown.
module block_fill_memory
  import mem_pkg::*;
#(
  parameter int ADDR_LEN        = mem_pkg::ADDR_LEN,
  parameter int WORD_LEN        = mem_pkg::WORD_LEN,
  parameter int WORDS_PER_BLOCK = mem_pkg::WORDS_PER_BLOCK,
  parameter int LATENCY         = mem_pkg::LATENCY
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   req_valid,
  output logic                                   req_ready,
  input  logic [ADDR_LEN-3:0]                    req_addr,
  output logic                                   resp_valid,
  input  logic                                   resp_ready,
  output logic [WORDS_PER_BLOCK*WORD_LEN-1:0]    resp_data,
  input  logic                                   wr_en,
  input  logic [ADDR_LEN-1:0]                    wr_addr,
  input  logic [WORD_LEN-1:0]                    wr_data
);
  mem_state_t                                state, state_nxt;
  logic [CNT_W-1:0]                          cnt;
  logic [ADDR_LEN-3:0]                       addr_q;
  logic [WORDS_PER_BLOCK*WORD_LEN-1:0]       data_q;
  logic [WORDS_PER_BLOCK-1:0][WORD_LEN-1:0]  tap;
  logic                                      accept, sample, cnt_dec;

  mem_word_array #(
    .ADDR_LEN (ADDR_LEN),
    .WORD_LEN (WORD_LEN),
    .WORDS    (WORDS_PER_BLOCK)
  ) u_array (
    .clk      (clk),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr  (addr_q),
    .rd_words (tap)
  );

  // State register; reset drops any request or response in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and datapath controls.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    sample    = 1'b0;
    cnt_dec   = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          sample    = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_dec   = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address capture, latency countdown and block sampling.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      if (accept) begin
        addr_q <= req_addr;
        cnt    <= CNT_W'(LATENCY - 1);
      end
      if (cnt_dec) cnt <= cnt - 1'b1;
      if (sample)  data_q <= tap;
    end
  end

  // Handshake outputs decode from state only; data comes from a register.
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_data  = data_q;
endmodule
